sm_clk_ctrl: RTL

Run/step/halt sequencer for the schoolMIPS core clock. It produces a one-cycle core enable pulse (coreTick) that the core uses to advance one instruction. Pulses come either at a divided rate in run mode, or one per debounced press of the step pushbutton in halt mode. The block sits between the board switches/buttons and sm_top's clock enable, and replaces the raw switch/button OR-ing in board top levels.

---
 rtl/sm_clk_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/sm_clk_ctrl.sv
// Run/step/halt sequencer producing the schoolMIPS core clock-enable pulse.
// Breakpoint support (pc/bpEnable/bpAddr/bpHit, BREAK state) is built with `define SM_CLK_CTRL_BREAK_EN.
module sm_clk_ctrl #(
  parameter int SHIFT      = 16,
  parameter int CNT_W      = 32,
  parameter int DEBOUNCE_W = 16,
  parameter int STEP_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              runMode,
  input  logic              stepBtn_n,
  input  logic [3:0]        devide,
  output logic              coreTick,
  output logic              running,
  output logic [STEP_W-1:0] stepCount,
`ifdef SM_CLK_CTRL_BREAK_EN
  input  logic [31:0]       pc,
  input  logic              bpEnable,
  input  logic [31:0]       bpAddr,
  output logic              bpHit,
`endif
  output logic [1:0]        dbg_state_o
);

  localparam int IW = $clog2(CNT_W);

  typedef enum logic [1:0] {
    ST_HALT      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP_HOLD = 2'd2,
    ST_BREAK     = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Two-flop synchronizers; reset to the released / stopped values.
  logic run_s1_q, run_s2_q;
  logic btn_s1_q, btn_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
      btn_s1_q <= 1'b1;
      btn_s2_q <= 1'b1;
    end else begin
      run_s1_q <= runMode;
      run_s2_q <= run_s1_q;
      btn_s1_q <= stepBtn_n;
      btn_s2_q <= btn_s1_q;
    end
  end

  logic run_sync, btn_sync;
  assign run_sync = run_s2_q;
  assign btn_sync = btn_s2_q;

  // Rate divider: a tick fires in the one cycle where the tap bit has just
  // risen (tap set, all lower bits clear), so a devide change cannot glitch.
  logic [CNT_W-1:0] cnt_q, cnt_d, low_mask;
  logic [IW-1:0]    tap_idx;
  logic             rate_tick;

  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    tap_idx   = IW'(SHIFT) + IW'(devide);
    low_mask  = (CNT_W'(1) << tap_idx) - CNT_W'(1);
    rate_tick = cnt_q[tap_idx] && ((cnt_q & low_mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Debounce: accept a new level after 2^DEBOUNCE_W consecutive differing cycles.
  logic [DEBOUNCE_W-1:0] db_cnt_q, db_cnt_d;
  logic                  stable_q, stable_d;
  logic                  step_press;
  // A press only counts once a debounced release has been seen since reset,
  // so a button held through reset cannot step the core.
  logic [DEBOUNCE_W-1:0] rel_cnt_q, rel_cnt_d;
  logic                  arm_q, arm_d;

  always_comb begin
    db_cnt_d   = db_cnt_q;
    stable_d   = stable_q;
    step_press = 1'b0;
    if (btn_sync == stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == '1) begin
      stable_d   = btn_sync;
      db_cnt_d   = '0;
      step_press = stable_q && arm_q;
    end else begin
      db_cnt_d = db_cnt_q + DEBOUNCE_W'(1);
    end
  end

  always_comb begin
    arm_d     = arm_q;
    rel_cnt_d = rel_cnt_q;
    if (!arm_q) begin
      if (stable_q && btn_sync) begin
        if (rel_cnt_q == '1) begin
          arm_d     = 1'b1;
          rel_cnt_d = '0;
        end else begin
          rel_cnt_d = rel_cnt_q + DEBOUNCE_W'(1);
        end
      end else begin
        rel_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q  <= '0;
      stable_q  <= 1'b1;
      rel_cnt_q <= '0;
      arm_q     <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      stable_q  <= stable_d;
      rel_cnt_q <= rel_cnt_d;
      arm_q     <= arm_d;
    end
  end

  logic core_tick_q, tick_d;
  logic running_q;
  logic [STEP_W-1:0] step_cnt_q;
  logic rate_ok;

  // Never let two run ticks touch, even across a devide change.
  assign rate_ok = rate_tick && !core_tick_q;

`ifdef SM_CLK_CTRL_BREAK_EN
  logic bp_match;
  logic bp_hit_q;
  assign bp_match = bpEnable && (pc == bpAddr);
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_HALT: begin
        if (run_sync) begin
          state_d = ST_RUN;
        end else if (step_press) begin
          tick_d  = 1'b1;
          state_d = ST_STEP_HOLD;
        end
      end
      ST_STEP_HOLD: begin
        if (stable_q) state_d = ST_HALT;
      end
      ST_RUN: begin
        if (!run_sync) begin
          state_d = ST_HALT;
        end else if (rate_ok) begin
`ifdef SM_CLK_CTRL_BREAK_EN
          if (bp_match) state_d = ST_BREAK;
          else          tick_d  = 1'b1;
`else
          tick_d = 1'b1;
`endif
        end
      end
`ifdef SM_CLK_CTRL_BREAK_EN
      ST_BREAK: begin
        if (!run_sync) state_d = ST_HALT;
      end
`endif
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HALT;
      core_tick_q <= 1'b0;
      running_q   <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      core_tick_q <= tick_d;
      running_q   <= (state_d == ST_RUN);
      step_cnt_q  <= step_cnt_q + STEP_W'(tick_d);
    end
  end

`ifdef SM_CLK_CTRL_BREAK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bp_hit_q <= 1'b0;
    else        bp_hit_q <= (state_d == ST_BREAK);
  end
  assign bpHit = bp_hit_q;
`endif

  assign coreTick    = core_tick_q;
  assign running     = running_q;
  assign stepCount   = step_cnt_q;
  assign dbg_state_o = state_q;

endmodule
